// File: rtl/dac_pkg.sv
// DAC write scheduler shared definitions.
// Holds the frame command bytes, the length and contents of the power-up
// init ROM, and the scheduler state encoding.
package dac_pkg;

  localparam logic [7:0] CMD_CFG   = 8'h06;
  localparam logic [7:0] CMD_DAC_A = 8'h08;
  localparam logic [7:0] CMD_DAC_B = 8'h09;

  localparam int         INIT_LEN  = 3;
  localparam logic [1:0] INIT_LAST = 2'(INIT_LEN - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } sched_state_t;

  // Init ROM: configuration word, then both channels parked at mid-scale.
  function automatic logic [31:0] init_rom(input logic [1:0] idx);
    logic [31:0] word;
    case (idx)
      2'd0:    word = {CMD_CFG,   24'h000000};
      2'd1:    word = {CMD_DAC_A, 24'h800000};
      2'd2:    word = {CMD_DAC_B, 24'h800000};
      default: word = {CMD_CFG,   24'h000000};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// 32-bit DAC serialiser.
// Ports: mck_i/rst_i clock and async active-low reset; start/frame load a
// word when not busy; busy is high while the frame is on the wire; done
// flags the last cycle of that frame; sync/sclk/sdo drive the DAC.
// sync drops together with the first sclk rise; each bit is sclk high for
// CLK_DIV cycles then low for CLK_DIV cycles; sdo only moves on sclk rises.
module dac_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        mck_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic [31:0] frame,
  output logic        busy,
  output logic        done,
  output logic        sync,
  output logic        sclk,
  output logic        sdo
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [30:0] sh_r;
  logic [7:0]  div_r;
  logic [4:0]  bits_r;
  logic        busy_r;
  logic        sync_r;
  logic        sclk_r;
  logic        sdo_r;
  logic        tick_s;

  assign tick_s = (div_r == DIV_LAST);
  // Final low half-period of bit 0 ends this cycle.
  assign done   = busy_r & tick_s & ~sclk_r & (bits_r == 5'd0);

  assign busy = busy_r;
  assign sync = sync_r;
  assign sclk = sclk_r;
  assign sdo  = sdo_r;

  // Frame load, half-period timing and MSB-first shifting.
  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) begin
      sh_r   <= 31'd0;
      div_r  <= 8'd0;
      bits_r <= 5'd0;
      busy_r <= 1'b0;
      sync_r <= 1'b1;
      sclk_r <= 1'b0;
      sdo_r  <= 1'b0;
    end else if (!busy_r) begin
      if (start) begin
        busy_r <= 1'b1;
        sync_r <= 1'b0;
        sclk_r <= 1'b1;
        sdo_r  <= frame[31];
        sh_r   <= frame[30:0];
        div_r  <= 8'd0;
        bits_r <= 5'd31;
      end
    end else if (!tick_s) begin
      div_r <= div_r + 8'd1;
    end else begin
      div_r <= 8'd0;
      if (sclk_r) begin
        sclk_r <= 1'b0;
      end else if (bits_r == 5'd0) begin
        busy_r <= 1'b0;
        sync_r <= 1'b1;
        sdo_r  <= 1'b0;
      end else begin
        sclk_r <= 1'b1;
        sdo_r  <= sh_r[30];
        sh_r   <= {sh_r[29:0], 1'b0};
        bits_r <= bits_r - 5'd1;
      end
    end
  end

endmodule

// File: rtl/dac_write_sched.sv
// DAC write scheduler.
// Ports: mck_i clock, rst_i async active-low reset; l_/r_valid+data sample
// strobes into 1-entry slots; cfg_valid/cmd/data with cfg_ready handshake;
// sync/sclk/sdo DAC serial bus; init_done after the init ROM is sent;
// overrun sticky when a full slot is overwritten.
// Arbitration in IDLE: left, right, config, except that a waiting config
// request wins after two sample frames have gone ahead of it.
module dac_write_sched
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic        mck_i,
  input  logic        rst_i,
  input  logic        l_valid,
  input  logic [23:0] l_data,
  input  logic        r_valid,
  input  logic [23:0] r_data,
  input  logic        cfg_valid,
  input  logic [7:0]  cfg_cmd,
  input  logic [23:0] cfg_data,
  output logic        cfg_ready,
  output logic        sync,
  output logic        sclk,
  output logic        sdo,
  output logic        init_done,
  output logic        overrun
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  sched_state_t state_r;
  logic [1:0]   init_idx_r;
  logic [7:0]   gap_r;
  logic [31:0]  frame_r;
  logic         sel_cfg_r;
  logic [1:0]   skip_r;
  logic         cfg_ready_r;
  logic         init_done_r;
  logic         l_full_r;
  logic [23:0]  l_slot_r;
  logic         r_full_r;
  logic [23:0]  r_slot_r;
  logic         overrun_r;

  logic         grant_l_s;
  logic         grant_r_s;
  logic         grant_c_s;
  logic [23:0]  l_pick_s;
  logic [23:0]  r_pick_s;
  logic         sh_start_s;
  logic [31:0]  sh_frame_s;
  logic         sh_busy_s;
  logic         sh_done_s;

  // A strobe arriving in IDLE is granted directly, saving a cycle of latency.
  assign l_pick_s   = l_full_r ? l_slot_r : l_data;
  assign r_pick_s   = r_full_r ? r_slot_r : r_data;
  assign sh_start_s = ((state_r == ST_INIT) || (state_r == ST_LOAD)) && !sh_busy_s;
  // Config word is taken live from the bus in the LOAD cycle, alongside cfg_ready.
  assign sh_frame_s = (state_r == ST_INIT) ? init_rom(init_idx_r) :
                      (sel_cfg_r ? {cfg_cmd, cfg_data} : frame_r);

  assign cfg_ready = cfg_ready_r;
  assign init_done = init_done_r;
  assign overrun   = overrun_r;

  // Grant selection for the IDLE cycle.
  always_comb begin
    grant_l_s = 1'b0;
    grant_r_s = 1'b0;
    grant_c_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (cfg_valid && (skip_r == 2'd2)) begin
        grant_c_s = 1'b1;
      end else if (l_valid || l_full_r) begin
        grant_l_s = 1'b1;
      end else if (r_valid || r_full_r) begin
        grant_r_s = 1'b1;
      end else if (cfg_valid) begin
        grant_c_s = 1'b1;
      end else begin
        grant_c_s = 1'b0;
      end
    end else begin
      grant_c_s = 1'b0;
    end
  end

  // Scheduler FSM: init sequencing, frame launch, gap timing, cfg handshake.
  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_INIT;
      init_idx_r  <= 2'd0;
      gap_r       <= 8'd0;
      frame_r     <= 32'd0;
      sel_cfg_r   <= 1'b0;
      skip_r      <= 2'd0;
      cfg_ready_r <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      cfg_ready_r <= 1'b0;
      case (state_r)
        ST_INIT: state_r <= ST_SHIFT;
        ST_IDLE: begin
          sel_cfg_r <= grant_c_s;
          if (grant_l_s) begin
            frame_r <= {CMD_DAC_A, l_pick_s};
            state_r <= ST_LOAD;
          end else if (grant_r_s) begin
            frame_r <= {CMD_DAC_B, r_pick_s};
            state_r <= ST_LOAD;
          end else if (grant_c_s) begin
            cfg_ready_r <= 1'b1;
            state_r     <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
          // Count sample frames that bypass a waiting config request.
          if (grant_c_s || !cfg_valid) begin
            skip_r <= 2'd0;
          end else if (grant_l_s || grant_r_s) begin
            skip_r <= skip_r + 2'd1;
          end
        end
        ST_LOAD: state_r <= ST_SHIFT;
        ST_SHIFT: begin
          if (sh_done_s) begin
            gap_r   <= 8'd0;
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_r != GAP_LAST) begin
            gap_r <= gap_r + 8'd1;
          end else if (init_done_r) begin
            state_r <= ST_IDLE;
          end else if (init_idx_r == INIT_LAST) begin
            init_done_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            init_idx_r <= init_idx_r + 2'd1;
            state_r    <= ST_INIT;
          end
        end
        default: state_r <= ST_INIT;
      endcase
    end
  end

  // Sample slots; a strobe in the grant cycle refills instead of overrunning.
  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) begin
      l_full_r  <= 1'b0;
      l_slot_r  <= 24'd0;
      r_full_r  <= 1'b0;
      r_slot_r  <= 24'd0;
      overrun_r <= 1'b0;
    end else begin
      if (l_valid) begin
        l_slot_r <= l_data;
      end
      if (r_valid) begin
        r_slot_r <= r_data;
      end
      l_full_r  <= grant_l_s ? (l_full_r & l_valid) : (l_full_r | l_valid);
      r_full_r  <= grant_r_s ? (r_full_r & r_valid) : (r_full_r | r_valid);
      overrun_r <= overrun_r | (l_valid & l_full_r & ~grant_l_s)
                             | (r_valid & r_full_r & ~grant_r_s);
    end
  end

  dac_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .mck_i (mck_i),
    .rst_i (rst_i),
    .start (sh_start_s),
    .frame (sh_frame_s),
    .busy  (sh_busy_s),
    .done  (sh_done_s),
    .sync  (sync),
    .sclk  (sclk),
    .sdo   (sdo)
  );

endmodule

// File: tb/tb_dac_write_sched.sv
`timescale 1ns/1ps
module tb_dac_write_sched;

  localparam int CLK_DIV = 1;
  localparam int GAP_CYC = 8;

  logic        mck_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        l_valid = 1'b0;
  logic [23:0] l_data = 24'd0;
  logic        r_valid = 1'b0;
  logic [23:0] r_data = 24'd0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_cmd = 8'd0;
  logic [23:0] cfg_data = 24'd0;
  logic        cfg_ready, sync, sclk, sdo, init_done, overrun;

  int n_checks = 0;
  int n_fail = 0;

  // Expected frames in wire order, filled by the stimulus.
  logic [31:0] exp_q[$];

  // Bus observer state.
  logic        prev_sync = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_sdo = 1'b0;
  logic        mon_valid = 1'b0;
  logic        seen_rise = 1'b0;
  logic [31:0] shreg = 32'd0;
  int nbits = 0;
  int low_cnt = 0;
  int high_cnt = 0;
  int frames_done = 0;
  int ready_cnt = 0;

  dac_write_sched #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .mck_i(mck_i), .rst_i(rst_i),
    .l_valid(l_valid), .l_data(l_data),
    .r_valid(r_valid), .r_data(r_data),
    .cfg_valid(cfg_valid), .cfg_cmd(cfg_cmd), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .sync(sync), .sclk(sclk), .sdo(sdo),
    .init_done(init_done), .overrun(overrun)
  );

  always #5 mck_i = ~mck_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge mck_i);
    #1;
  endtask

  task automatic wait_sync(input logic lvl, input int budget, input string name);
    int n = 0;
    while (sync !== lvl && n < budget) begin
      tick();
      n++;
    end
    if (sync !== lvl) timeout_fail(name);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || sync !== 1'b1) && n < 2000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) timeout_fail(name);
    repeat (GAP_CYC + 4) tick();
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (init_done !== 1'b1) timeout_fail(name);
  endtask

  task automatic check_first_frame_latency(input string name);
    int n = 0;
    while (sync === 1'b1 && n < 4) begin
      tick();
      n++;
    end
    check(name, 32'(n <= 2), 32'd1);
  endtask

  // Bus observer: protocol rules every cycle, frame decode against exp_q.
  initial begin
    forever begin
      @(negedge mck_i);
      if (!rst_i) begin
        mon_valid = 1'b0;
        seen_rise = 1'b0;
        nbits = 0;
        low_cnt = 0;
        high_cnt = 0;
      end else begin
        if (cfg_ready) ready_cnt++;
        if (sync) begin
          check("idle_sdo", 32'(sdo), 32'd0);
          check("idle_sclk", 32'(sclk), 32'd0);
        end
        if (mon_valid) begin
          if (!prev_sync && !sync) begin
            if (prev_sclk && !sclk) begin
              check("sdo_stable_at_fall", 32'(sdo), 32'(prev_sdo));
              shreg = {shreg[30:0], sdo};
              nbits++;
            end
            if (sdo != prev_sdo) check("sdo_moves_on_rise", 32'({prev_sclk, sclk}), 32'd1);
          end
          if (prev_sync && !sync) begin
            if (seen_rise) check("gap_min_len", 32'(high_cnt >= GAP_CYC), 32'd1);
            low_cnt = 0;
            nbits = 0;
            shreg = 32'd0;
          end
          if (!prev_sync && sync) begin
            check("frame_low_len", 32'(low_cnt), 32'(64 * CLK_DIV));
            check("frame_bits", 32'(nbits), 32'd32);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_frame: got 0x%08h, expected none", shreg);
            end else begin
              check("frame_data", shreg, exp_q.pop_front());
            end
            frames_done++;
            seen_rise = 1'b1;
            high_cnt = 0;
          end
        end
        if (!sync) low_cnt++;
        else high_cnt++;
        prev_sync = sync;
        prev_sclk = sclk;
        prev_sdo = sdo;
        mon_valid = 1'b1;
      end
    end
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;

    // Reset state.
    repeat (3) tick();
    check("rst_sync", 32'(sync), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Init sequence, with a left strobe parked in the slot meanwhile.
    exp_q.push_back(32'h06000000);
    exp_q.push_back(32'h08800000);
    exp_q.push_back(32'h09800000);
    exp_q.push_back(32'h080000AA);
    rst_i = 1'b1;
    check_first_frame_latency("init_start_latency");
    tick();
    l_valid = 1'b1;
    l_data = 24'h0000AA;
    tick();
    l_valid = 1'b0;
    check("init_done_low_during_init", 32'(init_done), 32'd0);
    wait_init("init_done_wait");
    check("init_frame_count", 32'(frames_done), 32'd3);
    check("slot_held_until_init", 32'(exp_q.size()), 32'd1);
    wait_drain("drain_init");
    check("overrun_clear_after_init", 32'(overrun), 32'd0);

    // Simultaneous left/right strobes, and IDLE->LOAD->SHIFT latency.
    exp_q.push_back(32'h08123456);
    exp_q.push_back(32'h09ABCDEF);
    l_valid = 1'b1;
    l_data = 24'h123456;
    r_valid = 1'b1;
    r_data = 24'hABCDEF;
    tick();
    l_valid = 1'b0;
    r_valid = 1'b0;
    lat = 1;
    while (sync === 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    check("grant_to_sync_latency", 32'(lat), 32'd2);
    wait_drain("drain_lr");
    check("overrun_clear_after_lr", 32'(overrun), 32'd0);

    // Config held while samples keep arriving: it must win after two frames.
    ready_cnt = 0;
    exp_q.push_back(32'h08111111);
    exp_q.push_back(32'h09222222);
    exp_q.push_back(32'h0A000003);
    exp_q.push_back(32'h08333333);
    cfg_valid = 1'b1;
    cfg_cmd = 8'h0A;
    cfg_data = 24'h000003;
    l_valid = 1'b1;
    l_data = 24'h111111;
    fork
      begin
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 2000) begin
          tick();
          n++;
        end
        if (cfg_ready !== 1'b1) timeout_fail("cfg_ready_wait");
        tick();
        cfg_valid = 1'b0;
      end
      begin
        tick();
        l_valid = 1'b0;
        wait_sync(1'b0, 100, "cfg_frame1_start");
        tick();
        r_valid = 1'b1;
        r_data = 24'h222222;
        tick();
        r_valid = 1'b0;
        wait_sync(1'b1, 200, "cfg_frame1_end");
        wait_sync(1'b0, 100, "cfg_frame2_start");
        tick();
        l_valid = 1'b1;
        l_data = 24'h333333;
        tick();
        l_valid = 1'b0;
      end
    join
    wait_drain("drain_cfg");
    check("cfg_ready_cycles", 32'(ready_cnt), 32'd1);
    check("overrun_clear_after_cfg", 32'(overrun), 32'd0);

    // Two left strobes within one frame: the second overwrites the first.
    exp_q.push_back(32'h09000055);
    exp_q.push_back(32'h08000002);
    r_valid = 1'b1;
    r_data = 24'h000055;
    tick();
    r_valid = 1'b0;
    wait_sync(1'b0, 100, "ovr_frame_start");
    tick();
    l_valid = 1'b1;
    l_data = 24'h000001;
    tick();
    l_valid = 1'b0;
    tick();
    check("overrun_after_first_strobe", 32'(overrun), 32'd0);
    tick();
    l_valid = 1'b1;
    l_data = 24'h000002;
    tick();
    l_valid = 1'b0;
    tick();
    check("overrun_set", 32'(overrun), 32'd1);
    wait_drain("drain_ovr");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a frame.
    exp_q.push_back(32'h08FFFFFF);
    l_valid = 1'b1;
    l_data = 24'hFFFFFF;
    tick();
    l_valid = 1'b0;
    wait_sync(1'b0, 100, "rst_frame_start");
    lat = 0;
    while (nbits < 10 && lat < 200) begin
      tick();
      lat++;
    end
    if (nbits < 10) timeout_fail("rst_bit10_wait");
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_sync", 32'(sync), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_sdo", 32'(sdo), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
    exp_q.delete();
    exp_q.push_back(32'h06000000);
    exp_q.push_back(32'h08800000);
    exp_q.push_back(32'h09800000);
    repeat (3) tick();
    base = frames_done;
    rst_i = 1'b1;
    check_first_frame_latency("reinit_start_latency");
    wait_init("reinit_done_wait");
    check("reinit_frame_count", 32'(frames_done - base), 32'd3);
    check("reinit_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (GAP_CYC + 4) tick();
    check("reinit_no_extra_frames", 32'(frames_done - base), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
